stream_demux_n: RTL and testbench



---
 rtl/stream_demux_pkg.sv | 28 ++
 rtl/stream_demux_decoder.sv | 36 +++
 rtl/stream_demux_n.sv | 85 ++++++++
 tb/tb_stream_demux_n.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants and the select decode helper for the stream demux.
// Combinational helpers only; no state.
// No flow control here; the top module owns the handshake.
package stream_demux_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_N_OUT  = 4;
  localparam int DEFAULT_CNT_W  = 8;

  // Widest channel count the block supports; decode masks are built at
  // this width and trimmed to N_OUT by the caller.
  localparam int MAX_N_OUT = 16;

  // One-hot mask with bit sel set, or all zeros when sel addresses a
  // channel that does not exist (sel >= n).
  function automatic logic [MAX_N_OUT-1:0] onehot_dec(input logic [31:0] sel,
                                                      input int unsigned n);
    logic [MAX_N_OUT-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_N_OUT; i++) begin
      if ((sel == i) && (i < n)) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/stream_demux_decoder.sv
// Binary select to one-hot channel mask, with enable and out-of-range flag.
// Purely combinational, zero latency.
// No backpressure; outputs follow inputs in the same cycle.
import stream_demux_pkg::*;

module demux_decoder #(
  parameter int SEL_W = 2,
  parameter int N_OUT = 4
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [N_OUT-1:0] onehot,
  output logic             oor
);

  localparam int unsigned N_U = N_OUT;

  logic [MAX_N_OUT-1:0] full_mask;
  // Bits above N_OUT are always zero for an in-range decode; folded here so
  // the trimmed-off bits are visibly consumed.
  logic                 unused_full_mask;

  assign full_mask        = onehot_dec(32'(sel), N_U);
  assign unused_full_mask = ^full_mask;

  // Mask is gated by enable so an idle cycle never addresses a channel.
  always_comb begin
    onehot = '0;
    oor    = 1'b0;
    if (en) begin
      onehot = full_mask[N_OUT-1:0];
      oor    = (32'(sel) >= N_U);
    end
  end

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1:N demux: routes a beat to one channel or broadcasts to all.
// One cycle from accept to out_valid; full throughput of one beat per cycle.
// in_ready drops while any addressed channel still holds an unaccepted beat.
import stream_demux_pkg::*;

module stream_demux_n #(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int N_OUT  = DEFAULT_N_OUT,
  parameter  int CNT_W  = DEFAULT_CNT_W,
  localparam int SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        drop_cnt
);

  logic [DATA_W-1:0] data_q;
  logic [N_OUT-1:0]  pend_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic [N_OUT-1:0]  sel_mask;
  logic              sel_oor;

  // Ready as soon as every still-pending channel is handshaking this cycle,
  // so a new beat can replace the draining one without a bubble.
  assign in_ready = ((pend_q & ~out_ready) == '0);
  assign accept   = in_valid && in_ready;

  demux_decoder #(
    .SEL_W (SEL_W),
    .N_OUT (N_OUT)
  ) u_decoder (
    .sel    (in_sel),
    .en     (accept && !in_bcast),
    .onehot (sel_mask),
    .oor    (sel_oor)
  );

  // Load a new beat on accept, otherwise retire channels that handshook.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      if (in_bcast) begin
        data_q <= in_data;
        pend_q <= '1;
        err_q  <= 1'b0;
      end else if (sel_oor) begin
        // Dropped beat: keep the old payload, just flag and count it.
        pend_q <= '0;
        err_q  <= 1'b1;
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        data_q <= in_data;
        pend_q <= sel_mask;
        err_q  <= 1'b0;
      end
    end else begin
      pend_q <= pend_q & ~out_ready;
      err_q  <= 1'b0;
    end
  end

  assign out_valid = pend_q;
  assign out_data  = {N_OUT{data_q}};
  assign sel_err   = err_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: a 4-channel instance for routing and
// flow control, and a 5-channel instance for out-of-range selects.
module tb_stream_demux_n;

  logic clk = 1'b0;
  logic rst_n;

  // 4-channel instance
  logic        in_valid4, in_ready4, in_bcast4, sel_err4;
  logic [7:0]  in_data4, drop_cnt4;
  logic [1:0]  in_sel4;
  logic [3:0]  out_valid4, out_ready4;
  logic [31:0] out_data4;

  // 5-channel instance
  logic        in_valid5, in_ready5, in_bcast5, sel_err5;
  logic [7:0]  in_data5, drop_cnt5;
  logic [2:0]  in_sel5;
  logic [4:0]  out_valid5, out_ready5;
  logic [39:0] out_data5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_demux_n #(.DATA_W(8), .N_OUT(4), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .in_sel(in_sel4), .in_bcast(in_bcast4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .sel_err(sel_err4), .drop_cnt(drop_cnt4)
  );

  stream_demux_n #(.DATA_W(8), .N_OUT(5), .CNT_W(8)) u5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .in_sel(in_sel5), .in_bcast(in_bcast5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
    .sel_err(sel_err5), .drop_cnt(drop_cnt5)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid4 = 0; in_bcast4 = 0; in_data4 = 0; in_sel4 = 0; out_ready4 = '1;
    in_valid5 = 0; in_bcast5 = 0; in_data5 = 0; in_sel5 = 0; out_ready5 = '1;
    #2;
    n_checks++;
    if (out_valid4 !== 4'b0000) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0000", out_valid4); end
    n_checks++;
    if (out_data4 !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data4); end
    n_checks++;
    if (in_ready4 !== 1'b1 || sel_err4 !== 1'b0 || drop_cnt4 !== 8'd0) begin
      n_fail++; $display("FAIL reset_misc: in_ready=%b sel_err=%b drop_cnt=%0d want 1 0 0", in_ready4, sel_err4, drop_cnt4);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_route();
    in_valid4 = 1; in_sel4 = 2'd2; in_data4 = 8'hA5; out_ready4 = 4'hF;
    #1;
    n_checks++;
    if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL route_in_ready: got %b want 1", in_ready4); end
    tick();
    in_valid4 = 0;
    n_checks++;
    if (out_valid4 !== 4'b0100) begin n_fail++; $display("FAIL route_out_valid: got %b want 0100", out_valid4); end
    n_checks++;
    if (out_data4[2*8 +: 8] !== 8'hA5 || out_data4 !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL route_out_data: got %h want a5a5a5a5", out_data4);
    end
    tick();
    n_checks++;
    if (out_valid4 !== 4'b0000) begin n_fail++; $display("FAIL route_drained: got %b want 0000", out_valid4); end
  endtask

  task automatic test_backpressure();
    in_valid4 = 1; in_sel4 = 2'd1; in_data4 = 8'h5A; out_ready4 = 4'b1101;
    tick();
    in_valid4 = 0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid4 !== 4'b0010 || in_ready4 !== 1'b0 || out_data4[8 +: 8] !== 8'h5A) begin
        n_fail++; $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b data=%h want 0010 0 5a",
                           k, out_valid4, in_ready4, out_data4[8 +: 8]);
      end
      tick();
    end
    // Release ch1 and offer the next beat in the same cycle.
    out_ready4 = 4'hF; in_valid4 = 1; in_sel4 = 2'd3; in_data4 = 8'h77;
    #1;
    n_checks++;
    if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready4); end
    tick();
    in_valid4 = 0;
    n_checks++;
    if (out_valid4 !== 4'b1000 || out_data4[3*8 +: 8] !== 8'h77) begin
      n_fail++; $display("FAIL bp_next_beat: out_valid=%b data=%h want 1000 77", out_valid4, out_data4[3*8 +: 8]);
    end
    tick();
  endtask

  task automatic test_bcast_drain();
    in_valid4 = 1; in_bcast4 = 1; in_sel4 = 2'd0; in_data4 = 8'h3C; out_ready4 = 4'b0000;
    tick();
    in_valid4 = 0; in_bcast4 = 0;
    n_checks++;
    if (out_valid4 !== 4'b1111 || in_ready4 !== 1'b0 || out_data4 !== 32'h3C3C3C3C) begin
      n_fail++; $display("FAIL bcast_load: out_valid=%b in_ready=%b data=%h want 1111 0 3c3c3c3c",
                         out_valid4, in_ready4, out_data4);
    end
    out_ready4 = 4'b1001;
    #1;
    n_checks++;
    if (in_ready4 !== 1'b0) begin n_fail++; $display("FAIL bcast_ready_a: got %b want 0", in_ready4); end
    tick();
    n_checks++;
    if (out_valid4 !== 4'b0110 || out_data4 !== 32'h3C3C3C3C) begin
      n_fail++; $display("FAIL bcast_mask_a: out_valid=%b data=%h want 0110 3c3c3c3c", out_valid4, out_data4);
    end
    out_ready4 = 4'b0010;
    #1;
    n_checks++;
    if (in_ready4 !== 1'b0) begin n_fail++; $display("FAIL bcast_ready_b: got %b want 0", in_ready4); end
    tick();
    n_checks++;
    if (out_valid4 !== 4'b0100 || out_data4[2*8 +: 8] !== 8'h3C) begin
      n_fail++; $display("FAIL bcast_mask_b: out_valid=%b data=%h want 0100 3c", out_valid4, out_data4[2*8 +: 8]);
    end
    out_ready4 = 4'b0100;
    #1;
    n_checks++;
    if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL bcast_ready_c: got %b want 1", in_ready4); end
    tick();
    n_checks++;
    if (out_valid4 !== 4'b0000) begin n_fail++; $display("FAIL bcast_mask_c: got %b want 0000", out_valid4); end
    out_ready4 = 4'hF;
  endtask

  task automatic test_back_to_back();
    int hs;
    hs = 0;
    out_ready4 = 4'hF;
    for (int k = 0; k < 8; k++) begin
      in_valid4 = 1; in_sel4 = 2'(k % 4); in_data4 = 8'(8'h10 + k);
      #1;
      n_checks++;
      if (in_ready4 !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", k, in_ready4); end
      tick();
      if ((out_valid4 & out_ready4) != 4'b0000) hs++;
      n_checks++;
      if (out_valid4 !== 4'(1 << (k % 4)) || out_data4[(k % 4)*8 +: 8] !== 8'(8'h10 + k)) begin
        n_fail++; $display("FAIL stream_beat[%0d]: out_valid=%b data=%h want %b %h",
                           k, out_valid4, out_data4[(k % 4)*8 +: 8], 4'(1 << (k % 4)), 8'(8'h10 + k));
      end
    end
    in_valid4 = 0;
    n_checks++;
    if (hs !== 8) begin n_fail++; $display("FAIL stream_handshakes: got %0d want 8", hs); end
    tick();
    n_checks++;
    if (out_valid4 !== 4'b0000) begin n_fail++; $display("FAIL stream_idle: got %b want 0000", out_valid4); end
  endtask

  task automatic test_out_of_range();
    // Highest legal channel on the 5-way instance.
    in_valid5 = 1; in_sel5 = 3'd4; in_data5 = 8'hC4; out_ready5 = '1;
    tick();
    n_checks++;
    if (out_valid5 !== 5'b10000 || out_data5[4*8 +: 8] !== 8'hC4 || sel_err5 !== 1'b0) begin
      n_fail++; $display("FAIL oor_ch4: out_valid=%b data=%h sel_err=%b want 10000 c4 0",
                         out_valid5, out_data5[4*8 +: 8], sel_err5);
    end
    in_sel5 = 3'd6; in_data5 = 8'hEE;
    tick();
    in_valid5 = 0;
    n_checks++;
    if (sel_err5 !== 1'b1 || drop_cnt5 !== 8'd1 || out_valid5 !== 5'b00000) begin
      n_fail++; $display("FAIL oor_drop: sel_err=%b drop_cnt=%0d out_valid=%b want 1 1 00000",
                         sel_err5, drop_cnt5, out_valid5);
    end
    n_checks++;
    if (out_data5[0 +: 8] !== 8'hC4) begin n_fail++; $display("FAIL oor_data_kept: got %h want c4", out_data5[0 +: 8]); end
    tick();
    n_checks++;
    if (sel_err5 !== 1'b0 || drop_cnt5 !== 8'd1) begin
      n_fail++; $display("FAIL oor_pulse_end: sel_err=%b drop_cnt=%0d want 0 1", sel_err5, drop_cnt5);
    end
    // Back-to-back drops keep the flag high every cycle.
    in_valid5 = 1; in_sel5 = 3'd7;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (sel_err5 !== 1'b1 || drop_cnt5 !== 8'(2 + k)) begin
        n_fail++; $display("FAIL oor_b2b[%0d]: sel_err=%b drop_cnt=%0d want 1 %0d", k, sel_err5, drop_cnt5, 2 + k);
      end
    end
    // 300 more drops push the counter well past its ceiling.
    repeat (300) tick();
    in_valid5 = 0;
    n_checks++;
    if (drop_cnt5 !== 8'd255) begin n_fail++; $display("FAIL oor_saturate: got %0d want 255", drop_cnt5); end
    tick();
    n_checks++;
    if (drop_cnt5 !== 8'd255 || sel_err5 !== 1'b0 || in_ready5 !== 1'b1) begin
      n_fail++; $display("FAIL oor_after: drop_cnt=%0d sel_err=%b in_ready=%b want 255 0 1", drop_cnt5, sel_err5, in_ready5);
    end
  endtask

  task automatic test_async_reset();
    in_valid4 = 1; in_sel4 = 2'd1; in_data4 = 8'h99; out_ready4 = 4'b0000;
    tick();
    in_valid4 = 0;
    n_checks++;
    if (out_valid4 !== 4'b0010 || in_ready4 !== 1'b0) begin
      n_fail++; $display("FAIL arst_setup: out_valid=%b in_ready=%b want 0010 0", out_valid4, in_ready4);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid4 !== 4'b0000 || in_ready4 !== 1'b1 || out_data4 !== 32'h0) begin
      n_fail++; $display("FAIL arst_clear: out_valid=%b in_ready=%b data=%h want 0000 1 0", out_valid4, in_ready4, out_data4);
    end
    n_checks++;
    if (drop_cnt4 !== 8'd0 || drop_cnt5 !== 8'd0) begin
      n_fail++; $display("FAIL arst_cnt: drop_cnt4=%0d drop_cnt5=%0d want 0 0", drop_cnt4, drop_cnt5);
    end
    tick();
    rst_n = 1'b1;
    out_ready4 = 4'hF;
    tick();
    n_checks++;
    if (out_valid4 !== 4'b0000) begin n_fail++; $display("FAIL arst_no_replay: got %b want 0000", out_valid4); end
  endtask

  initial begin
    test_reset();
    test_single_route();
    test_backpressure();
    test_bcast_drain();
    test_back_to_back();
    test_out_of_range();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
